// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// branch flush and data-memory wait sequencing with a timeout.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   id_*                  ID-stage instruction source operands
//   ex_*                  EX-stage register fields, control bits, branch outcome
//   mem_*, dmem_ack       MEM-stage destination, register write, memory handshake
//   wb_*                  WB-stage destination and register write
//   *_hold                hold the corresponding pipeline register
//   ifid_flush            load a NOP into IF/ID (overrides ifid_hold)
//   idex_bubble           load zeroed control into ID/EX
//   memwb_bubble          load zeroed control into MEM/WB
//   fwd_a, fwd_b          EX operand source: 00 regfile, 01 MEM, 10 WB
//   state                 00 RUN, 01 FLUSH, 10 MWAIT
//   mem_timeout           sticky memory-wait timeout flag
//   stall_cycles          saturating count of cycles with pc_hold
//   flush_count           saturating count of taken-branch redirects
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_RegWrite,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_RegWrite,
    input  logic             mem_access,
    input  logic             dmem_ack,
    input  logic [4:0]       wb_rd,
    input  logic             wb_RegWrite,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_FLUSH = 2'b01;
    localparam logic [1:0] S_MWAIT = 2'b10;

    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic memstall;
    logic loaduse;
    logic ev_freeze;
    logic ev_redirect;
    logic ev_lu_stall;
    logic ev_flush_slot;
    logic ifid_hold_raw;

    // A load's RegWrite is implied by MemRead, so ex_RegWrite plays no part.
    logic unused_inputs;
    assign unused_inputs = ex_RegWrite;

    assign memstall = mem_access & ~dmem_ack;

    assign loaduse = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

    // Forwarding: MEM result is newer than WB, so it wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == ex_rs1)
                fwd_a = 2'b01;
            else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs1)
                fwd_a = 2'b10;
            if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == ex_rs2)
                fwd_b = 2'b01;
            else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs2)
                fwd_b = 2'b10;
        end
    end

    // Event decode shared by the next-state and output logic.
    // The MWAIT ack cycle behaves like RUN; a timed-out wait never completes.
    always_comb begin
        ev_freeze     = 1'b0;
        ev_redirect   = 1'b0;
        ev_lu_stall   = 1'b0;
        ev_flush_slot = 1'b0;
        unique case (state_q)
            S_FLUSH: begin
                ev_flush_slot = 1'b1;
                ev_freeze     = memstall;
            end
            S_MWAIT: begin
                if (!dmem_ack || mem_timeout_q)
                    ev_freeze = 1'b1;
                else if (ex_branch_taken)
                    ev_redirect = 1'b1;
                else if (loaduse)
                    ev_lu_stall = 1'b1;
            end
            default: begin
                if (memstall)
                    ev_freeze = 1'b1;
                else if (ex_branch_taken)
                    ev_redirect = 1'b1;
                else if (loaduse)
                    ev_lu_stall = 1'b1;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = S_RUN;
        if (ev_freeze)
            state_d = S_MWAIT;
        else if (ev_redirect)
            state_d = S_FLUSH;

        wait_cnt_d = '0;
        if (state_q == S_MWAIT && state_d == S_MWAIT)
            wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q
                                                 : wait_cnt_q + 1'b1;

        mem_timeout_d = mem_timeout_q |
                        (state_d == S_MWAIT && wait_cnt_d == WC_MAX);
    end

    // Output logic; reset forces the pipeline into a safe flushed state.
    always_comb begin
        pc_hold       = 1'b0;
        ifid_hold_raw = 1'b0;
        idex_hold     = 1'b0;
        exmem_hold    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        memwb_bubble  = 1'b0;
        if (!rst_n) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            if (ev_freeze) begin
                pc_hold       = 1'b1;
                ifid_hold_raw = 1'b1;
                idex_hold     = 1'b1;
                exmem_hold    = 1'b1;
                memwb_bubble  = 1'b1;
            end
            if (ev_redirect) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            if (ev_lu_stall) begin
                pc_hold       = 1'b1;
                ifid_hold_raw = 1'b1;
                idex_bubble   = 1'b1;
            end
            if (ev_flush_slot)
                ifid_flush = 1'b1;
        end
        ifid_hold = ifid_hold_raw & ~ifid_flush;
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        if (pc_hold && stall_q != '1)
            stall_d = stall_q + 1'b1;
        flush_d = flush_q;
        if (ev_redirect && flush_q != '1)
            flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
            flush_q       <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
        end
    end

    assign state        = state_q;
    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected
// outputs per cycle, a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam int TO   = 255;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
    localparam int RUN  = 0;
    localparam int FL   = 1;
    localparam int MW   = 2;

    typedef struct packed {
        logic       rst_n;
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic       ex_valid;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_MemRead;
        logic       ex_RegWrite;
        logic       ex_branch_taken;
        logic [4:0] mem_rd;
        logic       mem_RegWrite;
        logic       mem_access;
        logic       dmem_ack;
        logic [4:0] wb_rd;
        logic       wb_RegWrite;
    } in_t;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [3:0]    fwd;
        logic [1:0]    st;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, id_valid, id_use_rs1, id_use_rs2, ex_valid;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_MemRead, ex_RegWrite, ex_branch_taken;
    logic mem_RegWrite, mem_access, dmem_ack, wb_RegWrite;
    logic pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic ifid_flush, idex_bubble, memwb_bubble, mem_timeout;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_chk = 0;
    int n_err = 0;
    exp_t q[$];

    int m_st, m_wait, m_sc, m_fc;
    bit m_to;
    int p_st, p_wait, p_sc, p_fc;
    bit p_to;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
        .ex_RegWrite(ex_RegWrite), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
        .mem_access(mem_access), .dmem_ack(dmem_ack),
        .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] src(input in_t s, input logic [4:0] rs);
        if (s.mem_RegWrite && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
        if (s.wb_RegWrite && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic apply(input in_t s);
        rst_n = s.rst_n; id_valid = s.id_valid;
        id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2;
        ex_valid = s.ex_valid; ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2;
        ex_rd = s.ex_rd; ex_MemRead = s.ex_MemRead;
        ex_RegWrite = s.ex_RegWrite; ex_branch_taken = s.ex_branch_taken;
        mem_rd = s.mem_rd; mem_RegWrite = s.mem_RegWrite;
        mem_access = s.mem_access; dmem_ack = s.dmem_ack;
        wb_rd = s.wb_rd; wb_RegWrite = s.wb_RegWrite;
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs and the
    // model state that the next rising edge will produce.
    task automatic drive(input in_t s);
        exp_t e;
        bit ms, lu, hold, took, lus, flush;
        bit pc, ifid, idex, exm, idb, mwb;
        int nxt;
        apply(s);
        ms = s.mem_access && !s.dmem_ack;
        lu = s.ex_valid && s.ex_MemRead && s.ex_rd != 0 && s.id_valid &&
             ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) ||
              (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
        hold = 0; took = 0; lus = 0; flush = 0; nxt = RUN;
        pc = 0; ifid = 0; idex = 0; exm = 0; idb = 0; mwb = 0;
        e = '0;
        e.st = 2'(m_st); e.to = m_to;
        e.sc = CW'(m_sc); e.fc = CW'(m_fc);
        if (!s.rst_n) begin
            flush = 1; idb = 1; mwb = 1;
        end else begin
            e.fwd = {src(s, s.ex_rs1), src(s, s.ex_rs2)};
            if (m_st == FL) begin
                flush = 1;
                hold = ms;
            end else if (m_st == MW && (!s.dmem_ack || m_to)) begin
                hold = 1;
            end else if (ms) begin
                hold = 1;
            end else if (s.ex_branch_taken) begin
                took = 1;
            end else if (lu) begin
                lus = 1;
            end
            if (hold) begin
                pc = 1; idex = 1; exm = 1; mwb = 1; ifid = !flush;
                nxt = MW;
            end
            if (took) begin
                flush = 1; idb = 1; nxt = FL;
            end
            if (lus) begin
                pc = 1; ifid = 1; idb = 1;
            end
        end
        e.ctl = {pc, ifid, idex, exm, flush, idb, mwb};
        q.push_back(e);
        if (!s.rst_n) begin
            p_st = RUN; p_wait = 0; p_to = 0; p_sc = 0; p_fc = 0;
        end else begin
            p_st = nxt;
            p_wait = (nxt == MW && m_st == MW) ? sat(m_wait + 1, TO) : 0;
            p_to = m_to || (nxt == MW && p_wait == TO);
            p_sc = sat(m_sc + int'(pc), MAXC);
            p_fc = sat(m_fc + int'(took), MAXC);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_st = p_st; m_wait = p_wait; m_to = p_to;
        m_sc = p_sc; m_fc = p_fc;
        #1;
    endtask

    task automatic step(input in_t s);
        drive(s);
        tick();
    endtask

    task automatic do_reset();
        in_t s;
        s = idle();
        s.rst_n = 1'b0;
        step(s);
        step(s);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a.ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                         ifid_flush, idex_bubble, memwb_bubble};
                a.fwd = {fwd_a, fwd_b};
                a.st = state; a.to = mem_timeout;
                a.sc = stall_cycles; a.fc = flush_count;
                chk("ctl", 32'(a.ctl), 32'(e.ctl));
                chk("fwd", 32'(a.fwd), 32'(e.fwd));
                chk("state", 32'({a.to, a.st}), 32'({e.to, e.st}));
                chk("cnt", 32'({a.sc, a.fc}), 32'({e.sc, e.fc}));
            end
        end
    end

    initial begin : stim
        in_t s;
        apply('0);
        m_st = RUN; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset outputs
        s = idle(); s.rst_n = 1'b0;
        drive(s); #1;
        chk("rst_flush", ifid_flush, 1);
        chk("rst_bubbles", {idex_bubble, memwb_bubble}, 2'b11);
        chk("rst_holds", {pc_hold, ifid_hold, idex_hold, exmem_hold}, 0);
        tick();

        // Load-use on rs1=x5
        s = idle();
        s.ex_valid = 1; s.ex_MemRead = 1; s.ex_RegWrite = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_use_rs1 = 1; s.id_rs1 = 5;
        drive(s); #1;
        chk("lu_hold", {pc_hold, ifid_hold, idex_bubble}, 3'b111);
        tick();
        drive(idle()); #1;
        chk("lu_state", state, RUN);
        chk("lu_stall", stall_cycles, 1);
        tick();

        // Taken branch
        do_reset();
        s = idle(); s.ex_branch_taken = 1;
        drive(s); #1;
        chk("br_n", {ifid_flush, idex_bubble}, 2'b11);
        tick();
        drive(idle()); #1;
        chk("br_fstate", state, FL);
        chk("br_n1", ifid_flush, 1);
        tick();
        drive(idle()); #1;
        chk("br_run", {state, ifid_flush}, 0);
        chk("br_cnt", flush_count, 1);
        tick();

        // Memory wait: 3 stalled cycles then ack
        do_reset();
        s = idle(); s.mem_access = 1;
        for (int i = 0; i < 3; i++) begin
            drive(s); #1;
            chk("mw_hold", {pc_hold, ifid_hold, idex_hold,
                            exmem_hold, memwb_bubble}, 5'h1f);
            tick();
        end
        s.dmem_ack = 1;
        drive(s); #1;
        chk("mw_ack", {pc_hold, ifid_hold, idex_hold, exmem_hold}, 0);
        tick();
        drive(idle()); #1;
        chk("mw_stall", stall_cycles, 3);
        tick();

        // Branch together with memstall
        do_reset();
        s = idle(); s.mem_access = 1; s.ex_branch_taken = 1;
        drive(s); #1;
        chk("bm_noflush", ifid_flush, 0);
        tick();
        chk("bm_mwait", state, MW);
        s.dmem_ack = 1;
        drive(s); #1;
        chk("bm_flush", {ifid_flush, idex_bubble}, 2'b11);
        tick();
        step(idle());

        // Forwarding priority
        s = idle();
        s.mem_RegWrite = 1; s.mem_rd = 7;
        s.wb_RegWrite = 1; s.wb_rd = 7; s.ex_rs1 = 7;
        drive(s); #1;
        chk("fwd_mem", fwd_a, 2'b01);
        tick();
        s.mem_rd = 0;
        drive(s); #1;
        chk("fwd_wb", fwd_a, 2'b10);
        tick();

        // Reset mid-FLUSH and mid-MWAIT leaves nothing behind
        s = idle(); s.ex_branch_taken = 1;
        step(s);
        do_reset();
        drive(idle()); #1;
        chk("rfl_clear", {ifid_flush, idex_bubble, pc_hold}, 0);
        tick();
        s = idle(); s.mem_access = 1;
        step(s); step(s);
        do_reset();
        drive(idle()); #1;
        chk("rmw_clear", {pc_hold, ifid_hold, memwb_bubble, state}, 0);
        tick();

        // Timeout
        s = idle(); s.mem_access = 1;
        for (int i = 0; i < 300; i++) begin
            drive(s); #1;
            if (i == 255) chk("to_before", mem_timeout, 0);
            if (i == 256) chk("to_set", mem_timeout, 1);
            tick();
        end
        chk("to_state", state, MW);
        chk("stall_sat", stall_cycles, MAXC);
        s.dmem_ack = 1;
        drive(s); #1;
        chk("to_stuck", pc_hold, 1);
        tick();
        do_reset();
        drive(idle()); #1;
        chk("to_clear", {mem_timeout, state}, 0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.id_valid = 1'($urandom_range(0, 1));
            s.id_rs1 = 5'($urandom_range(0, 3));
            s.id_rs2 = 5'($urandom_range(0, 3));
            s.id_use_rs1 = 1'($urandom_range(0, 1));
            s.id_use_rs2 = 1'($urandom_range(0, 1));
            s.ex_valid = 1'($urandom_range(0, 1));
            s.ex_rs1 = 5'($urandom_range(0, 3));
            s.ex_rs2 = 5'($urandom_range(0, 3));
            s.ex_rd = 5'($urandom_range(0, 3));
            s.ex_MemRead = 1'($urandom_range(0, 1));
            s.ex_RegWrite = 1'($urandom_range(0, 1));
            s.ex_branch_taken = ($urandom_range(0, 5) == 0);
            s.mem_rd = 5'($urandom_range(0, 3));
            s.mem_RegWrite = 1'($urandom_range(0, 1));
            s.mem_access = ($urandom_range(0, 3) == 0);
            s.dmem_ack = ($urandom_range(0, 2) != 0);
            s.wb_rd = 5'($urandom_range(0, 3));
            s.wb_RegWrite = 1'($urandom_range(0, 1));
            step(s);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have these parameters: TIMEOUT, default 255, max MWAIT cycles before mem_timeout; CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- ex_valid  in  1  EX stage valid
- ex_rs1, ex_rs2, ex_rd  in  5 each  EX register fields
- ex_MemRead, ex_RegWrite  in  1 each  EX control bits
- ex_branch_taken  in  1  branch or jump in EX resolved taken
- mem_rd  in  5  MEM destination register
- mem_RegWrite  in  1  MEM writes the register file
- mem_access  in  1  MEM stage issues a load or store
- dmem_ack  in  1  data memory completes the access this cycle
- wb_rd  in  5  WB destination register
- wb_RegWrite  in  1  WB writes the register file
- pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  hold the register
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load zeroed control into ID/EX
- memwb_bubble  out  1  load zeroed control into MEM/WB
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 MEM, 10 WB
- state  out  2  00 RUN, 01 FLUSH, 10 MWAIT
- mem_timeout  out  1  sticky error
- stall_cycles, flush_count  out  CNT_W each  saturating performance counters

Function
REQ-003 Forwarding SHALL be combinational and independent of state.
REQ-004 fwd_a SHALL be 01 if mem_RegWrite, mem_rd!=0 and mem_rd==ex_rs1; otherwise 10 if wb_RegWrite, wb_rd!=0 and wb_rd==ex_rs1; otherwise 00. MEM takes priority over WB.
REQ-005 fwd_b SHALL follow the same rule as REQ-004, using ex_rs2.
REQ-006 memstall = mem_access & !dmem_ack.
REQ-007 loaduse = ex_valid & ex_MemRead & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-008 The event priority SHALL be: memstall, then branch, then loaduse.
REQ-009 In RUN with memstall, the block SHALL assert pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_bubble in the same cycle, and next state SHALL be MWAIT.
REQ-010 In RUN with !memstall and ex_branch_taken, the block SHALL assert ifid_flush and idex_bubble, next state SHALL be FLUSH, and flush_count SHALL increment.
REQ-011 In RUN with only loaduse, the block SHALL assert pc_hold, ifid_hold and idex_bubble for that cycle, and state SHALL stay RUN.
REQ-012 In FLUSH, the block SHALL assert ifid_flush for exactly one cycle, to discard the synchronous-fetch instruction, and SHALL ignore loaduse.
REQ-013 In FLUSH, next state SHALL be RUN, or MWAIT if memstall. With memstall, the REQ-009 holds SHALL also assert.
REQ-014 In MWAIT, all four holds and memwb_bubble SHALL stay asserted while dmem_ack=0.
REQ-015 In the MWAIT cycle with dmem_ack=1, all holds SHALL deassert and next state SHALL be RUN; branch and loaduse SHALL be evaluated normally in that cycle.
REQ-016 ifid_flush SHALL dominate ifid_hold when both are asserted.
REQ-017 An internal wait counter SHALL count consecutive MWAIT cycles and clear on leaving MWAIT.
REQ-018 When the wait counter reaches TIMEOUT, mem_timeout SHALL set and stay set until reset; the FSM SHALL remain in MWAIT.
REQ-019 stall_cycles SHALL increment in every cycle with pc_hold=1.
REQ-020 Both counters SHALL saturate at all-ones and never wrap.
REQ-021 Holds and flushes not specified for a state/event SHALL be 0.

Reset
REQ-022 On a rising clk with rst_n=0, state SHALL become RUN, and the wait counter, stall_cycles, flush_count and mem_timeout SHALL become 0.
REQ-023 While rst_n=0, the outputs SHALL be: ifid_flush=1, idex_bubble=1, memwb_bubble=1, all holds 0, fwd_a=fwd_b=00.
REQ-024 Reset asserted mid-MWAIT or mid-FLUSH SHALL abandon the sequence, with no residual hold or flush after rst_n rises.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Load x5 in EX; ID reads rs1=5 -> one cycle pc_hold=ifid_hold=idex_bubble=1, state RUN, stall_cycles=1.
- ex_branch_taken=1 -> cycle N: ifid_flush=idex_bubble=1, state->FLUSH; cycle N+1: ifid_flush=1, then RUN, flush_count=1.
- mem_access=1, dmem_ack low for 3 cycles then high -> 3 cycles of all holds plus memwb_bubble, holds 0 in the ack cycle, stall_cycles=3.
- Taken branch plus memstall in the same cycle -> MWAIT entered, no flush; after ack, branch flush occurs.
- MEM and WB both write x7 while ex_rs1=7 -> fwd_a=01; set mem_rd=0 -> fwd_a=10.
- dmem_ack held 0 for 300 cycles -> mem_timeout=1 at cycle 255; rst_n=0 then clears it and returns state to RUN.
